// File: rtl/ins_encoder.sv
// ins_encoder: streaming RV32I instruction encoder.
// Two-stage pipeline: stage 1 registers the fields plus a range-check error
// bit; stage 2 packs the 32-bit word and presents it with its address.
// Optional feature macro: ENCODER_ZICSR_EN (CSR/CSRI packing). Without it,
// formats 6/7 always report an error and emit a zero word.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload until that edge; ready
// may depend combinationally on the consumer's ready but never on valid.
`timescale 1ns/1ps
module ins_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_op_base,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] count,
  output logic        busy
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_CSR  = 3'd6;
  localparam logic [2:0] FMT_CSRI = 3'd7;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] BR_MIN    = -32'sd4096;
  localparam logic signed [31:0] BR_MAX    = 32'sd4094;
  localparam logic signed [31:0] JAL_MIN   = -32'sd1048576;
  localparam logic signed [31:0] JAL_MAX   = 32'sd1048574;

  // Stage 1 state
  logic        s1_valid_q;
  logic [2:0]  s1_fmt_q;
  logic [4:0]  s1_op_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [31:0] s1_imm_q;
  logic        s1_err_q;
  logic        s1_shift_q;

  // Stage 2 state
  logic        s2_valid_q;
  logic [31:0] ins_q;
  logic        err_q;
  logic [31:0] pc_q;
  logic [15:0] count_q;

  logic        in_fire, s2_load, out_fire;
  logic        shift_d, chk_err_d;
  logic [31:0] pack_ins_d;
  logic [6:0]  opcode;
  logic signed [31:0] imm_s;

  // A stage loads when empty or when its contents leave this cycle; start blocks intake.
  assign in_ready = !start && (!s1_valid_q || !s2_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_fire = s2_valid_q && out_ready;

  assign imm_s   = in_imm;
  assign shift_d = (in_op_base == 5'b00100) &&
                   ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign opcode  = {s1_op_q, 2'b11};

  // Range check of the incoming immediate for its format.
  always_comb begin
    chk_err_d = 1'b0;
    case (in_fmt)
      FMT_R: chk_err_d = 1'b0;
      FMT_I: begin
        if (shift_d) chk_err_d = |in_imm[31:5];
        else         chk_err_d = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_S: chk_err_d = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      FMT_B: chk_err_d = (imm_s < BR_MIN) || (imm_s > BR_MAX) || in_imm[0];
      FMT_U: chk_err_d = |in_imm[11:0];
      FMT_J: chk_err_d = (imm_s < JAL_MIN) || (imm_s > JAL_MAX) || in_imm[0];
      FMT_CSR, FMT_CSRI: begin
`ifdef ENCODER_ZICSR_EN
        chk_err_d = |in_imm[31:12];
`else
        chk_err_d = 1'b1;
`endif
      end
    endcase
  end

  // Pack the stage-1 fields into the standard RV32I layout; errors emit zero.
  always_comb begin
    pack_ins_d = 32'h0;
    case (s1_fmt_q)
      FMT_R: pack_ins_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, opcode};
      FMT_I: begin
        if (s1_shift_q) pack_ins_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, opcode};
        else            pack_ins_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, opcode};
      end
      FMT_S: pack_ins_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], opcode};
      FMT_B: pack_ins_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                           s1_imm_q[4:1], s1_imm_q[11], opcode};
      FMT_U: pack_ins_d = {s1_imm_q[31:12], s1_rd_q, opcode};
      FMT_J: pack_ins_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                           s1_rd_q, opcode};
      FMT_CSR, FMT_CSRI: begin
`ifdef ENCODER_ZICSR_EN
        // For CSRI the rs1 field already carries the 5-bit uimm.
        pack_ins_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, opcode};
`else
        pack_ins_d = 32'h0;
`endif
      end
    endcase
    if (s1_err_q) pack_ins_d = 32'h0;
  end

  // Stage 1: capture fields and error bit on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= 3'd0;
      s1_op_q    <= 5'd0;
      s1_f3_q    <= 3'd0;
      s1_f7_q    <= 7'd0;
      s1_rd_q    <= 5'd0;
      s1_rs1_q   <= 5'd0;
      s1_rs2_q   <= 5'd0;
      s1_imm_q   <= 32'd0;
      s1_err_q   <= 1'b0;
      s1_shift_q <= 1'b0;
    end else if (start) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_fmt_q   <= in_fmt;
      s1_op_q    <= in_op_base;
      s1_f3_q    <= in_funct3;
      s1_f7_q    <= in_funct7;
      s1_rd_q    <= in_rd;
      s1_rs1_q   <= in_rs1;
      s1_rs2_q   <= in_rs2;
      s1_imm_q   <= in_imm;
      s1_err_q   <= chk_err_d;
      s1_shift_q <= shift_d;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: hold the packed word until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      ins_q      <= 32'h0;
      err_q      <= 1'b0;
    end else if (start) begin
      s2_valid_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      ins_q      <= pack_ins_d;
      err_q      <= s1_err_q;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Address and handshake counters; start overrides any same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'h0;
      count_q <= 16'h0;
    end else if (start) begin
      pc_q    <= base_addr & 32'hFFFF_FFFC;
      count_q <= 16'h0;
    end else if (out_fire) begin
      pc_q <= pc_q + 32'd4;
      if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ins   = ins_q;
  assign out_err   = err_q;
  assign out_addr  = pc_q;
  assign count     = count_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: doc/ins_encoder.md
# ins_encoder

Streaming RV32I instruction encoder: the inverse of the instruction decoder. Accepts structured instruction fields (format, opcode, functs, register addresses, immediate) over a valid/ready handshake. Range-checks and packs them into 32-bit instruction words, then emits each word with a running write address over a second valid/ready handshake. Used by the boot/self-test loader to build programs in instruction memory and by the verification harness to generate decoder stimulus.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: load `base_addr`, clear `count`, flush the pipeline.
- `base_addr`  in  32  first output address; bits [1:0] are ignored and treated as 0.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder accepts the input fields this cycle.
- `in_fmt`  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR, 7=CSRI.
- `in_op_base`  in  5  opcode[6:2]; opcode[1:0] is always emitted as 2'b11.
- `in_funct3`  in  3  funct3.
- `in_funct7`  in  7  funct7. Used by R, and by I when it is a shift.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register fields. For CSRI, `in_rs1` carries the uimm.
- `in_imm`  in  32  signed immediate. For CSR/CSRI, [11:0] is the CSR address.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  consumer accepts the encoded word.
- `out_ins`  out  32  encoded instruction.
- `out_addr`  out  32  word-aligned address of `out_ins`.
- `out_err`  out  1  input was unencodable; `out_ins` is 32'h0000_0000.
- `count`  out  16  output handshakes since the last `start` or reset. Saturates at 16'hFFFF.
- `busy`  out  1  at least one pipeline stage is valid.

## Operation
- Stage 1 (check): registers the fields plus an error bit.
- Stage 2 (pack): registers `out_ins`, `out_err` and `out_addr`.
- Error conditions:
  - I/S: immediate outside [-2048, 2047].
  - B: immediate outside [-4096, 4094], or imm[0] is 1.
  - J: immediate outside [-1048576, 1048574], or imm[0] is 1.
  - U: imm[11:0] is not 0.
  - I-shift (`in_op_base`=5'b00100, funct3 001/101): imm[31:5] is not 0. The word uses {in_funct7, imm[4:0]} in bits [31:20].
  - CSR/CSRI: imm[31:12] is not 0.
- Packing uses the standard RV32I field layouts. U places imm[31:12] in bits [31:12]. CSRI places the uimm in bits [19:15].
- Errored entries still flow through, occupy an address and advance `count`; `out_ins` is 0.
- Address counter `pc`:
  - Loaded from `base_addr` on `start`.
  - Advanced by 4 on each output handshake; `out_addr` is `pc` for the current word.
  - Wraps from 32'hFFFF_FFFC to 0.
- Pipeline advance rule: a stage loads when it is empty or its contents leave this cycle.
  - `in_ready` = !s1_valid || (!s2_valid || out_ready), gated low while `start` is high.
- `start` when `in_valid` is also high: `start` wins, the input is not accepted, and both stage valids clear.
- An output handshake in the same cycle as `start` is still delivered. `count` and `pc` take their `start` values, not the incremented ones.

## Timing
- Reset values (all outputs):
  - `out_valid`=0, `out_ins`=0, `out_err`=0, `out_addr`=0, `count`=0, `busy`=0.
  - Internal `pc`=0.
  - `in_ready`=1 from the first cycle after `rst_n` deasserts.
- Latency: input handshake at edge N gives `out_valid`=1 after edge N+1, provided stage 2 is free.
- Throughput: 1 word/cycle while `out_ready`=1.
- With `out_ready` held low, the encoder accepts at most 2 inputs, then drops `in_ready`.
- `out_*` holds stable while `out_valid`=1 and `out_ready`=0.
- `rst_n` asserted mid-stream drops in-flight words immediately, with no handshake.

## Configuration
- `ENCODER_ZICSR_EN`:
  - Defined: CSR and CSRI formats encode (opcode from `in_op_base`, normally 5'b11100).
  - Undefined: `in_fmt` 6/7 always sets `out_err`=1 and `out_ins`=0, and the CSR packing logic is absent.

## Test plan
- Reset, `start` with `base_addr`=0x100, then addi x1,x0,5 (fmt I, op_base 5'b00100, imm 5) -> `out_ins`=0x00500093, `out_addr`=0x100, `out_err`=0, `count`=1.
- lui x2 (fmt U, op_base 5'b01101, imm 0x12345000) -> 0x12345137. Same with imm 0x12345001 -> `out_err`=1, `out_ins`=0.
- beq x1,x2,-4 (fmt B, op_base 5'b11000, imm -4) -> 0xFE208EE3. imm -3 -> `out_err`=1.
- csrrw x1,0x300,x2 (fmt CSR, funct3 001) -> 0x300110F3 with `ENCODER_ZICSR_EN` defined; `out_err`=1 without it.
- `out_ready`=0 with 3 back-to-back inputs:
  - Only 2 are accepted and `in_ready` drops.
  - After releasing `out_ready`, words emerge in order at base, base+4, base+8.
  - `base_addr`=0xFFFF_FFFC: the second word's address wraps to 0.
- `start` pulsed while 2 words are in flight and `in_valid`=1 -> `busy`=0 next cycle, `count`=0, and the input is not accepted.
